bfm_ahbl_slave_mem: RTL
=======================

Name: bfm_ahbl_slave_mem

Overview:
- AHB-Lite slave responder BFM: the target end of the AHB-Lite bus driven by the team's AHB-Lite master BFM.
- Models a word-organised memory with a programmable number of wait states and a configurable error window.
- Decodes AHB-Lite transfers, inserts wait states, returns OKAY or two-cycle ERROR responses, and performs byte/halfword/word writes and reads.
- Used in testbenches as a generic slave behind the BFM master or a bus fabric.

Parameters:
- MEM_AW, 10, word-address width; memory depth is 2**MEM_AW 32-bit words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in each OKAY data phase (0..15).
- ERR_BASE, 32'hFFFF_F000, first byte address of the error window.
- ERR_SIZE, 0, byte size of the error window; 0 disables the window.
- TPD, 1, output delay in ns, applied to registered outputs only (simulation).

Ports:
- HCLK  input  1  bus clock; all logic on its rising edge.
- HRESET  input  1  reset, synchronous, active-high.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address.
- HTRANS  input  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size: 0 byte, 1 half, 2 word.
- HBURST  input  3  accepted but ignored.
- HWDATA  input  32  write data, valid in the data phase.
- HREADYIN  input  1  bus-level HREADY.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Clock and reset: one clock (HCLK). HRESET is synchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. Memory contents are not reset.
- Accept condition: HSEL & HREADYIN & HTRANS[1]. On accept, latch HADDR, HWRITE and HSIZE and enter the data phase on the next cycle.
- IDLE/BUSY transfers, and cycles with HSEL=0, get a zero-wait OKAY response and cause no memory access.
- Error detection at accept: the transfer is an error if any of these hold:
  - HSIZE>2;
  - misaligned (half with HADDR[0]=1, or word with HADDR[1:0]!=0);
  - ERR_SIZE!=0 and ERR_BASE <= HADDR < ERR_BASE+ERR_SIZE (32-bit unsigned compare, no wrap).
- FSM states and transitions:
  - IDLE: HREADYOUT=1, HRESP=0. On accept, go to ERR1 if error, else DATA if WAIT_STATES==0, else WAIT.
  - WAIT: HREADYOUT=0, HRESP=0. Counter counts 1..WAIT_STATES, then go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. Completes the transfer. If a new accept occurs in the same cycle (pipelined address phase), go directly to the next ERR1, WAIT or DATA state; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A pipelined accept is still honoured. If the master drives HTRANS=IDLE after ERR1, it is simply not accepted.
- Writes:
  - Commit at the HCLK edge that ends the DATA cycle.
  - Word index = latched HADDR[MEM_AW+1:2]; upper bits are ignored (address aliases/wraps).
  - Byte lanes are little-endian from HADDR[1:0] and HSIZE. Only the enabled lanes of HWDATA are written.
  - Error transfers never write.
- Reads:
  - HRDATA = mem[index] combinationally while in a read DATA cycle; 0 otherwise (including ERR1/ERR2).
  - The full word is returned; the master selects lanes.
- Read-after-write: a read whose data phase directly follows a write's DATA cycle to the same word returns the new data.
- Reset mid-transfer: return to IDLE on the next edge; any pending write is dropped.

Optional Feature:
- Macro: BFM_AHBL_SLAVE_RANDWAIT_EN.
- Defined: a 16-bit Galois LFSR (seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1) advances once per accept. The effective wait count per transfer is WAIT_STATES + lfsr[1:0] (0..3 extra cycles). The LFSR reseeds on HRESET.
- Undefined: the wait count is exactly WAIT_STATES and no LFSR logic exists.

Decomposition:
- Package bfm_ahbl_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE encodings;
  - HRESP encodings;
  - the state enum (IDLE, WAIT, DATA, ERR1, ERR2);
  - a function computing the 4-bit byte-lane mask from addr[1:0] and size.
- One sub-module, bfm_ahbl_slave_ram: a single-port 32-bit RAM with byte enables, combinational read, synchronous write.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HREADYOUT never low; read returns 0xDEADBEEF in the cycle after the write's data phase.
- WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, then high with data, HRESP=0.
- Byte write 0xAA to 0x13, then half-word write 0x1234 to 0x10, then word read 0x10 -> 0xAA001234 when the word was pre-zeroed.
- ERR_BASE=0x100, ERR_SIZE=0x10: write to 0x108 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a following read of 0x108's alias confirms memory is unchanged.
- Misaligned word access at 0x2 and HSIZE=3 -> two-cycle ERROR each; IDLE/BUSY cycles with HSEL=1 -> zero-wait OKAY, no write.
- Assert HRESET during a WAIT cycle of a write -> next cycle HREADYOUT=1, HRESP=0, state IDLE; read-back shows the old data.

Source files
------------

// File: rtl/bfm_ahbl_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper for the
// AHB-Lite slave memory BFM.
package bfm_ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian byte-lane enables; illegal sizes enable no lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [2:0] size);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bfm_ahbl_slave_ram.sv
// Single-port 32-bit word RAM with byte enables: combinational read,
// write on the rising clock edge.
module bfm_ahbl_slave_ram #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    // NOTE: the array has no reset; contents stay undefined until written,
    // just like a real SRAM, and a reset branch would block RAM inference.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite slave memory BFM: wait states, two-cycle ERROR responses, byte-lane writes.
// Define BFM_AHBL_SLAVE_RANDWAIT_EN to add 0..3 LFSR-driven extra wait states per transfer.
module bfm_ahbl_slave_mem
    import bfm_ahbl_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000,
    parameter logic [31:0] ERR_SIZE    = 32'h0,
    parameter int          TPD         = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [MEM_AW+1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              accept, acc_err, in_win;
    logic [32:0]       win_end;
    logic [4:0]        acc_wait, wait_tgt;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    // Only the states that drive HREADYOUT high can take a new address phase.
    assign accept = HSEL & HREADYIN & HTRANS[1] &
                    ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));

    assign win_end = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};
    assign in_win  = (ERR_SIZE != 32'h0) && (HADDR >= ERR_BASE) && ({1'b0, HADDR} < win_end);
    assign acc_err = (HSIZE > 3'd2) ||
                     ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                     in_win;

`ifdef BFM_AHBL_SLAVE_RANDWAIT_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  wait_tgt_q;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lfsr_q     <= 16'hACE1;
            wait_tgt_q <= 5'd0;
        end else if (accept) begin
            lfsr_q     <= lfsr_d;
            wait_tgt_q <= acc_wait;
        end
    end

    assign acc_wait = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
    assign wait_tgt = wait_tgt_q;
`else
    assign acc_wait = 5'(WAIT_STATES);
    assign wait_tgt = 5'(WAIT_STATES);
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = 5'd0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (acc_err) begin
                    state_d = ST_ERR1;
                end else if (acc_wait == 5'd0) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 5'd1;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q >= wait_tgt) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address-phase capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q  <= HADDR[MEM_AW+1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
        end
    end

    assign ram_we = (state_q == ST_DATA) && write_q && !HRESET;

    bfm_ahbl_slave_ram #(.AW(MEM_AW)) u_ram (
        .clk_i   (HCLK),
        .we_i    (ram_we),
        .be_i    (lane_mask(addr_q[1:0], size_q)),
        .addr_i  (addr_q[MEM_AW+1:2]),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

    assign HRDATA = ((state_q == ST_DATA) && !write_q) ? ram_rdata : 32'h0;

    // HBURST carries no meaning for a memory target; TPD is kept for interface compatibility.
    logic unused_ok;
    assign unused_ok = ^{HBURST, 32'(TPD)};

endmodule
